// File: rtl/lsu_mem_port_if.sv
// Bus bundle for lsu_mem_port: the CPU request/response handshake plus the PSRAM wrapper pulse/ready interface.
interface lsu_mem_port_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              ram_ren;
    logic              ram_wen;
    logic [31:0]       ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_bsel;
    logic              ram_ready;
    logic [31:0]       ram_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, ram_ready, ram_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output ram_ren, ram_wen, ram_addr, ram_wdata, ram_bsel
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, ram_ready, ram_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  ram_ren, ram_wen, ram_addr, ram_wdata, ram_bsel
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store port in front of the PSRAM data RAM wrapper: one access per handshake, busy/idle tracking, timeout.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/HU/W accesses respond with err=1 instead of touching RAM.
module lsu_mem_port #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_W         = 32
) (
    input  logic           clk,
    input  logic           reset,
    lsu_mem_port_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_r;
    state_t            state_s;
    logic              store_r;
    logic [2:0]        f3_r;
    logic [1:0]        off_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              req_ready_r;
    logic              resp_valid_r;
    logic [31:0]       resp_rdata_r;
    logic              resp_err_r;
    logic [31:0]       ram_addr_r;
    logic [31:0]       ram_wdata_r;
    logic [3:0]        ram_bsel_r;

    logic [ADDR_W-1:0] req_addr_s;
    logic [31:0]       addr32_s;
    logic              handshake_s;
    logic              legal_s;
    logic              resp_err_s;
    logic [31:0]       resp_rdata_s;

    function automatic logic f3_legal(input logic st, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = ~st;
            default:                f3_legal = 1'b0;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction
`endif

    // Halfwords only honour off[1]; a stray off[0] is dropped when misalignment is not trapped.
    function automatic logic [3:0] byte_sel(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   byte_sel = 4'b0001 << off;
            2'b01:   byte_sel = 4'b0011 << {off[1], 1'b0};
            2'b10:   byte_sel = 4'b1111;
            default: byte_sel = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   store_data = {4{wd[7:0]}};
            2'b01:   store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] f3,
                                                 input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b010:  load_extract = w;
            3'b100:  load_extract = {24'h000000, b};
            3'b101:  load_extract = {16'h0000, h};
            default: load_extract = 32'h0000_0000;
        endcase
    endfunction

    assign req_addr_s  = bus.req_addr;
    assign addr32_s    = 32'(req_addr_s);
    assign handshake_s = (state_r == IDLE) && bus.req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
    assign legal_s = f3_legal(bus.req_store, bus.req_funct3) &&
                     !misaligned(bus.req_funct3, req_addr_s[1:0]);
`else
    assign legal_s = f3_legal(bus.req_store, bus.req_funct3);
`endif

    // Next-state, response error and response data selection.
    always_comb begin
        state_s      = state_r;
        resp_err_s   = 1'b0;
        resp_rdata_s = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                if (handshake_s && !legal_s) begin
                    state_s    = RESP;
                    resp_err_s = 1'b1;
                end else if (handshake_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (bus.ram_ready) begin
                    state_s = WAIT_ACK;
                end else begin
                    state_s = ISSUE;
                end
            end
            WAIT_ACK: begin
                if (!bus.ram_ready) begin
                    state_s = WAIT_DONE;
                end else if (cnt_r == TMO_LAST) begin
                    state_s    = RESP;
                    resp_err_s = 1'b1;
                end else begin
                    state_s = WAIT_ACK;
                end
            end
            WAIT_DONE: begin
                // Completion in the final allowed cycle wins over the timeout.
                if (bus.ram_ready) begin
                    state_s      = RESP;
                    resp_rdata_s = store_r ? 32'h0000_0000 : load_extract(bus.ram_rdata, f3_r, off_r);
                end else if (cnt_r == TMO_LAST) begin
                    state_s    = RESP;
                    resp_err_s = 1'b1;
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Timeout counter: cleared while issuing, counts the acknowledge/completion wait.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (state_r == WAIT_ACK || state_r == WAIT_DONE) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= '0;
        end
    end

    // Request capture; RAM-side address/data/enables only change for accesses that will reach the RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            store_r     <= 1'b0;
            f3_r        <= 3'b000;
            off_r       <= 2'b00;
            ram_addr_r  <= 32'h0000_0000;
            ram_wdata_r <= 32'h0000_0000;
            ram_bsel_r  <= 4'b0000;
        end else if (handshake_s) begin
            store_r <= bus.req_store;
            f3_r    <= bus.req_funct3;
            off_r   <= req_addr_s[1:0];
            if (legal_s) begin
                ram_addr_r  <= {addr32_s[31:2], 2'b00};
                ram_wdata_r <= store_data(bus.req_funct3, bus.req_wdata);
                ram_bsel_r  <= byte_sel(bus.req_funct3, req_addr_s[1:0]);
            end else begin
                ram_addr_r  <= ram_addr_r;
                ram_wdata_r <= ram_wdata_r;
                ram_bsel_r  <= ram_bsel_r;
            end
        end else begin
            store_r     <= store_r;
            f3_r        <= f3_r;
            off_r       <= off_r;
            ram_addr_r  <= ram_addr_r;
            ram_wdata_r <= ram_wdata_r;
            ram_bsel_r  <= ram_bsel_r;
        end
    end

    // Registered CPU-side outputs, derived from the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
        end else begin
            req_ready_r  <= (state_s == IDLE);
            resp_valid_r <= (state_s == RESP);
            resp_rdata_r <= resp_rdata_s;
            resp_err_r   <= resp_err_s;
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
    // The pulse must land in the first ISSUE cycle that sees the RAM idle, so it is gated by ram_ready directly.
    assign bus.ram_ren    = (state_r == ISSUE) && bus.ram_ready && !store_r;
    assign bus.ram_wen    = (state_r == ISSUE) && bus.ram_ready && store_r;
    assign bus.ram_addr   = ram_addr_r;
    assign bus.ram_wdata  = ram_wdata_r;
    assign bus.ram_bsel   = ram_bsel_r;
endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a small PSRAM busy/idle responder; TIMEOUT_CYCLES is set to 8.
module tb_lsu_mem_port;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lsu_mem_port_if #(.ADDR_W(32)) bus_if ();

    lsu_mem_port #(.TIMEOUT_CYCLES(8), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    // RAM responder: after a pulse it goes busy for busy_len cycles (unless ack_en is 0).
    int          busy_len  = 7;
    logic        ack_en    = 1'b1;
    int          pulse_cnt = 0;
    int          busy_r;
    logic [31:0] cap_addr  = 32'h0;
    logic [31:0] cap_wdata = 32'h0;
    logic [3:0]  cap_bsel  = 4'h0;
    logic        cap_we    = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_if.ram_ready <= 1'b1;
            busy_r           <= 0;
        end else if (bus_if.ram_ren || bus_if.ram_wen) begin
            pulse_cnt <= pulse_cnt + 1;
            cap_addr  <= bus_if.ram_addr;
            cap_wdata <= bus_if.ram_wdata;
            cap_bsel  <= bus_if.ram_bsel;
            cap_we    <= bus_if.ram_wen;
            if (ack_en) begin
                bus_if.ram_ready <= 1'b0;
                busy_r           <= busy_len - 1;
            end
        end else if (busy_r > 0) begin
            busy_r <= busy_r - 1;
        end else begin
            bus_if.ram_ready <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd, output logic er,
                           output int lat);
        @(negedge clk);
        check("req_ready_idle", 32'(bus_if.req_ready), 32'd1);
        bus_if.req_valid  = 1'b1;
        bus_if.req_store  = st;
        bus_if.req_funct3 = f3;
        bus_if.req_addr   = a;
        bus_if.req_wdata  = wd;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        lat = 0;
        rd  = 32'hXXXX_XXXX;
        er  = 1'bx;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus_if.resp_valid) begin
                rd = bus_if.resp_rdata;
                er = bus_if.resp_err;
                break;
            end
        end
        @(negedge clk);
        check("resp_one_cycle", 32'(bus_if.resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          p0;
        int          seen;

        reset             = 1'b0;
        bus_if.req_valid  = 1'b0;
        bus_if.req_store  = 1'b0;
        bus_if.req_funct3 = 3'b000;
        bus_if.req_addr   = 32'h0;
        bus_if.req_wdata  = 32'h0;
        bus_if.ram_rdata  = 32'h80FF_1234;
        repeat (3) @(negedge clk);
        check("rst_req_ready",  32'(bus_if.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
        check("rst_resp_rdata", bus_if.resp_rdata, 32'h0);
        check("rst_resp_err",   32'(bus_if.resp_err), 32'd0);
        check("rst_ren_wen",    32'({bus_if.ram_ren, bus_if.ram_wen}), 32'd0);
        check("rst_ram_addr",   bus_if.ram_addr, 32'h0);
        check("rst_ram_wdata",  bus_if.ram_wdata, 32'h0);
        check("rst_ram_bsel",   32'(bus_if.ram_bsel), 32'd0);
        reset = 1'b1;

        // SW, RAM busy 7 cycles: pulse at 1, busy 2..8, idle at 9, response at 10.
        busy_len = 7;
        p0 = pulse_cnt;
        run_req(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, rd, er, lat);
        check("sw_lat",    32'(lat), 32'd10);
        check("sw_err",    32'(er), 32'd0);
        check("sw_rdata",  rd, 32'h0);
        check("sw_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("sw_we",     32'(cap_we), 32'd1);
        check("sw_addr",   cap_addr, 32'h0000_0100);
        check("sw_bsel",   32'(cap_bsel), 32'hF);
        check("sw_wdata",  cap_wdata, 32'hDEAD_BEEF);

        busy_len = 2;
        run_req(1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, rd, er, lat);
        check("sb_lat",   32'(lat), 32'd5);
        check("sb_err",   32'(er), 32'd0);
        check("sb_addr",  cap_addr, 32'h0000_0200);
        check("sb_bsel",  32'(cap_bsel), 32'h8);
        check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);

        busy_len = 1;
        run_req(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, rd, er, lat);
        check("sh_lat",   32'(lat), 32'd4);
        check("sh_bsel",  32'(cap_bsel), 32'hC);
        check("sh_wdata", cap_wdata, 32'hABCD_ABCD);

        // Loads against ram_rdata 0x80FF1234.
        busy_len = 2;
        run_req(1'b0, 3'b000, 32'h0000_0003, 32'h0, rd, er, lat);
        check("lb3_rdata", rd, 32'hFFFF_FF80);
        check("lb3_lat",   32'(lat), 32'd5);
        check("lb3_we",    32'(cap_we), 32'd0);
        check("lb3_bsel",  32'(cap_bsel), 32'h8);
        check("lb3_addr",  cap_addr, 32'h0);
        run_req(1'b0, 3'b100, 32'h0000_0003, 32'h0, rd, er, lat);
        check("lbu3_rdata", rd, 32'h0000_0080);
        run_req(1'b0, 3'b101, 32'h0000_0002, 32'h0, rd, er, lat);
        check("lhu2_rdata", rd, 32'h0000_80FF);
        run_req(1'b0, 3'b001, 32'h0000_0002, 32'h0, rd, er, lat);
        check("lh2_rdata", rd, 32'hFFFF_80FF);
        run_req(1'b0, 3'b001, 32'h0000_0000, 32'h0, rd, er, lat);
        check("lh0_rdata", rd, 32'h0000_1234);
        run_req(1'b0, 3'b000, 32'h0000_0001, 32'h0, rd, er, lat);
        check("lb1_rdata", rd, 32'h0000_0012);
        run_req(1'b0, 3'b010, 32'h0000_0010, 32'h0, rd, er, lat);
        check("lw_rdata", rd, 32'h80FF_1234);
        check("lw_err",   32'(er), 32'd0);
        check("lw_addr",  cap_addr, 32'h0000_0010);

        // Illegal funct3 codes answer in one cycle without touching RAM.
        p0 = pulse_cnt;
        run_req(1'b0, 3'b011, 32'h0000_0000, 32'h0, rd, er, lat);
        check("ill_ld011_lat", 32'(lat), 32'd1);
        check("ill_ld011_err", 32'(er), 32'd1);
        check("ill_ld011_rd",  rd, 32'h0);
        run_req(1'b1, 3'b100, 32'h0000_0000, 32'h0, rd, er, lat);
        check("ill_st100_err", 32'(er), 32'd1);
        run_req(1'b0, 3'b110, 32'h0000_0000, 32'h0, rd, er, lat);
        check("ill_ld110_err", 32'(er), 32'd1);
        check("ill_pulses",    32'(pulse_cnt - p0), 32'd0);

        // No acknowledge: 8 cycles in WAIT_ACK (2..9), response at 10.
        ack_en = 1'b0;
        p0 = pulse_cnt;
        run_req(1'b0, 3'b010, 32'h0000_0040, 32'h0, rd, er, lat);
        check("tmo_lat",    32'(lat), 32'd10);
        check("tmo_err",    32'(er), 32'd1);
        check("tmo_rdata",  rd, 32'h0);
        check("tmo_pulses", 32'(pulse_cnt - p0), 32'd1);
        ack_en = 1'b1;

        p0 = pulse_cnt;
        run_req(1'b0, 3'b010, 32'h0000_0102, 32'h0, rd, er, lat);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_lat",    32'(lat), 32'd1);
        check("mis_err",    32'(er), 32'd1);
        check("mis_pulses", 32'(pulse_cnt - p0), 32'd0);
`else
        check("mis_lat",    32'(lat), 32'd5);
        check("mis_err",    32'(er), 32'd0);
        check("mis_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("mis_addr",   cap_addr, 32'h0000_0100);
        check("mis_rdata",  rd, 32'h80FF_1234);
`endif

        // Reset during WAIT_DONE aborts the access with no response.
        busy_len = 7;
        @(negedge clk);
        bus_if.req_valid  = 1'b1;
        bus_if.req_store  = 1'b1;
        bus_if.req_funct3 = 3'b010;
        bus_if.req_addr   = 32'h0000_0300;
        bus_if.req_wdata  = 32'h1122_3344;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_addr", bus_if.ram_addr, 32'h0000_0300);
        reset = 1'b0;
        @(negedge clk);
        check("abort_req_ready",  32'(bus_if.req_ready), 32'd1);
        check("abort_resp_valid", 32'(bus_if.resp_valid), 32'd0);
        check("abort_ram_addr",   bus_if.ram_addr, 32'h0);
        check("abort_ram_wdata",  bus_if.ram_wdata, 32'h0);
        check("abort_ram_bsel",   32'(bus_if.ram_bsel), 32'd0);
        check("abort_ren_wen",    32'({bus_if.ram_ren, bus_if.ram_wen}), 32'd0);
        reset = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus_if.resp_valid) seen++;
        end
        check("abort_no_resp", 32'(seen), 32'd0);

        busy_len = 2;
        run_req(1'b0, 3'b010, 32'h0000_0004, 32'h0, rd, er, lat);
        check("post_lat",   32'(lat), 32'd5);
        check("post_err",   32'(er), 32'd0);
        check("post_rdata", rd, 32'h80FF_1234);
        check("post_addr",  cap_addr, 32'h0000_0004);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit port sitting directly upstream of the PSRAM data RAM wrapper.
- Accepts one RISC-V load/store (LB/LH/LW/LBU/LHU/SB/SH/SW) per handshake from the CPU memory stage.
- Issues a one-cycle ren/wen pulse with a word address, replicated store data and a byte-enable vector, then tracks the RAM busy/idle signal until completion.
- Returns aligned, sign-/zero-extended load data with a response strobe; flags timeout and misalignment errors.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles spent in WAIT_ACK+WAIT_DONE before aborting with error.
- ADDR_W, 32, CPU byte-address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  unit idle, request accepted when req_valid&&req_ready.
- req_store  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  extended load data (0 for stores/errors).
- resp_err  out  1  valid with resp_valid: timeout, misalign or illegal funct3.
- ram_ren  out  1  read pulse to RAM.
- ram_wen  out  1  write pulse to RAM.
- ram_addr  out  32  word-aligned address (bits[1:0]=00).
- ram_wdata  out  32  byte-lane-replicated store data.
- ram_bsel  out  4  byte enables, active-high, bit i = byte lane i.
- ram_ready  in  1  RAM idle (1) / busy (0).
- ram_rdata  in  32  RAM read word.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, ram_ren=0, ram_wen=0, ram_addr=0, ram_wdata=0, ram_bsel=0; state IDLE; timeout counter 0.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP.
- IDLE: req_ready=1. On handshake, latch store, funct3, addr[1:0] and wdata; go to ISSUE.
- IDLE, illegal funct3 (011, 11x, or 1xx on a store): go straight to RESP with err=1; no RAM access.
- ISSUE: waits until ram_ready=1, then pulses ram_ren or ram_wen for exactly one cycle with ram_addr/ram_wdata/ram_bsel valid in that cycle; go to WAIT_ACK. ram_addr/ram_bsel/ram_wdata hold until RESP.
- WAIT_ACK: waits for ram_ready=0, then goes to WAIT_DONE.
- WAIT_DONE: waits for ram_ready=1 and samples ram_rdata in that cycle; go to RESP.
- Timeout: counter clears on entering WAIT_ACK and increments each cycle in WAIT_ACK/WAIT_DONE. When it reaches TIMEOUT_CYCLES-1 without completing, go to RESP with err=1 and rdata=0.
- RESP: resp_valid=1 for one cycle, then IDLE. req_ready=0 in all states except IDLE.
- Byte enables: B→4'b0001<<off; H→4'b0011<<off; W→4'b1111 (off=addr[1:0]).
- Store data: B→{4{wdata[7:0]}}; H→{2{wdata[15:0]}}; W→wdata.
- Load extract: byte at ram_rdata[8*off+:8]; half at [16*off[1]+:16]; sign-extended for B/H, zero-extended for BU/HU.
- Minimum latency: handshake at cycle 0; ren/wen pulse at cycle 1 if ram_ready=1; resp_valid one cycle after the ram_ready rising edge.
- Reset asserted mid-operation aborts immediately to reset values. No response is produced for the aborted request.
- req_valid while busy is ignored; the CPU must hold the request until accepted.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined: H/HU with addr[0]=1, or W with addr[1:0]≠0, goes IDLE→RESP with err=1 and no RAM pulse.
- Not defined: misaligned low address bits are ignored. H uses off[1] only; W uses off=0. Access proceeds normally with err=0.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, RAM busy 7 cycles → one wen pulse, ram_addr 0x100, bsel 4'b1111; resp_valid, err=0.
- SB addr 0x203, wdata 0x000000A5 → ram_addr 0x200, bsel 4'b1000, ram_wdata 0xA5A5A5A5.
- LB addr 0x3 with ram_rdata 0x80FF1234 → resp_rdata 0xFFFFFF80; LBU → 0x00000080; LHU addr 0x2 → 0x000080FF.
- ram_ready held 1 after the ren pulse (no ack), TIMEOUT_CYCLES=8 → resp_valid after 8 cycles in WAIT_ACK, err=1, rdata 0.
- LW addr 0x102: with LSU_MISALIGN_TRAP_EN → no ren, err=1. Without it → ren at 0x100, err=0.
- Reset deasserted→asserted during WAIT_DONE → all outputs at reset values next cycle; next request completes normally.
